// File: rtl/stream_demux2_4b.sv
// Two-way 4-bit stream demultiplexer. Each output has a 2-entry FIFO.
// Define STREAM_DEMUX2_4B_COUNT_EN to add 8-bit delivered-message counters.
//
// Handshake: a transfer happens on any port in a cycle where val && rdy at
// the rising edge. The source holds val/msg while waiting. in_rdy depends
// only on in_sel and registered occupancy, never on out*_rdy.
module stream_demux2_4b (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [3:0] in_msg,
  input  logic       in_sel,
  output logic       out0_val,
  input  logic       out0_rdy,
  output logic [3:0] out0_msg,
  output logic       out1_val,
  input  logic       out1_rdy,
  output logic [3:0] out1_msg
`ifdef STREAM_DEMUX2_4B_COUNT_EN
  ,
  output logic [7:0] out0_count,
  output logic [7:0] out1_count
`endif
);

  logic [3:0] mem  [2][2];
  logic       head [2];
  logic       tail [2];
  logic [1:0] cnt  [2];

  logic       accept;
  logic [1:0] enq;
  logic [1:0] deq;
  logic [1:0] out_rdy;
  logic [1:0] out_val;

  assign out_rdy = {out1_rdy, out0_rdy};

  // Outputs are forced idle while reset is held so nothing stale leaks out.
  assign out_val[0] = !reset && (cnt[0] != 2'd0);
  assign out_val[1] = !reset && (cnt[1] != 2'd0);

  assign in_rdy = !reset && (in_sel ? (cnt[1] < 2'd2) : (cnt[0] < 2'd2));
  assign accept = in_val && in_rdy;
  assign enq[0] = accept && !in_sel;
  assign enq[1] = accept && in_sel;
  assign deq    = out_val & out_rdy;

  assign out0_val = out_val[0];
  assign out1_val = out_val[1];
  assign out0_msg = out_val[0] ? mem[0][head[0]] : 4'b0000;
  assign out1_msg = out_val[1] ? mem[1][head[1]] : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        head[i]   <= 1'b0;
        tail[i]   <= 1'b0;
        cnt[i]    <= 2'd0;
        mem[i][0] <= 4'b0000;
        mem[i][1] <= 4'b0000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (enq[i]) begin
          mem[i][tail[i]] <= in_msg;
          tail[i]         <= ~tail[i];
        end
        if (deq[i]) begin
          head[i] <= ~head[i];
        end
        case ({enq[i], deq[i]})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

`ifdef STREAM_DEMUX2_4B_COUNT_EN
  logic [7:0] dcount [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      dcount[0] <= 8'd0;
      dcount[1] <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (deq[i]) begin
          dcount[i] <= dcount[i] + 8'd1;
        end
      end
    end
  end

  assign out0_count = dcount[0];
  assign out1_count = dcount[1];
`endif

endmodule

// File: tb/tb_stream_demux2_4b.sv
// Self-checking bench for stream_demux2_4b: directed steps plus a random
// phase, with a per-output expected queue checked every cycle.
module tb_stream_demux2_4b;

  logic       clk;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [3:0] in_msg;
  logic       in_sel;
  logic       out0_val;
  logic       out0_rdy;
  logic [3:0] out0_msg;
  logic       out1_val;
  logic       out1_rdy;
  logic [3:0] out1_msg;
`ifdef STREAM_DEMUX2_4B_COUNT_EN
  logic [7:0] out0_count;
  logic [7:0] out1_count;
  logic [7:0] mcnt0;
  logic [7:0] mcnt1;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] exp0_q[$];
  logic [3:0] exp1_q[$];

  stream_demux2_4b dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .in_sel   (in_sel),
    .out0_val (out0_val),
    .out0_rdy (out0_rdy),
    .out0_msg (out0_msg),
    .out1_val (out1_val),
    .out1_rdy (out1_rdy),
    .out1_msg (out1_msg)
`ifdef STREAM_DEMUX2_4B_COUNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver helpers: drive just after the rising edge, sample on the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: compare every cycle against the expected queues, then
  // apply the handshakes that the next rising edge will commit.
  logic       e_rdy;
  logic       e0v;
  logic       e1v;
  logic [3:0] e0m;
  logic [3:0] e1m;

  always @(negedge clk) begin
    e0v   = !reset && (exp0_q.size() != 0);
    e1v   = !reset && (exp1_q.size() != 0);
    e0m   = e0v ? exp0_q[0] : 4'h0;
    e1m   = e1v ? exp1_q[0] : 4'h0;
    e_rdy = !reset && (in_sel ? (exp1_q.size() < 2) : (exp0_q.size() < 2));
    chk("sb_in_rdy",   {7'd0, in_rdy},   {7'd0, e_rdy});
    chk("sb_out0_val", {7'd0, out0_val}, {7'd0, e0v});
    chk("sb_out1_val", {7'd0, out1_val}, {7'd0, e1v});
    chk("sb_out0_msg", {4'd0, out0_msg}, {4'd0, e0m});
    chk("sb_out1_msg", {4'd0, out1_msg}, {4'd0, e1m});
`ifdef STREAM_DEMUX2_4B_COUNT_EN
    chk("sb_out0_count", out0_count, mcnt0);
    chk("sb_out1_count", out1_count, mcnt1);
`endif
    if (reset) begin
      exp0_q.delete();
      exp1_q.delete();
`ifdef STREAM_DEMUX2_4B_COUNT_EN
      mcnt0 = 8'd0;
      mcnt1 = 8'd0;
`endif
    end else begin
      if (e0v && out0_rdy) begin
        void'(exp0_q.pop_front());
`ifdef STREAM_DEMUX2_4B_COUNT_EN
        mcnt0 = mcnt0 + 8'd1;
`endif
      end
      if (e1v && out1_rdy) begin
        void'(exp1_q.pop_front());
`ifdef STREAM_DEMUX2_4B_COUNT_EN
        mcnt1 = mcnt1 + 8'd1;
`endif
      end
      if (in_val && e_rdy) begin
        if (in_sel) exp1_q.push_back(in_msg);
        else        exp0_q.push_back(in_msg);
      end
    end
  end

  initial begin
`ifdef STREAM_DEMUX2_4B_COUNT_EN
    mcnt0 = 8'd0;
    mcnt1 = 8'd0;
`endif
    reset    = 1'b1;
    in_val   = 1'b0;
    in_msg   = 4'h0;
    in_sel   = 1'b0;
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    mid();
    chk("post_reset_in_rdy",   {7'd0, in_rdy},   8'd1);
    chk("post_reset_out0_val", {7'd0, out0_val}, 8'd0);
    chk("post_reset_out1_val", {7'd0, out1_val}, 8'd0);

    // Single message to out0
    cyc();
    in_val = 1'b1; in_sel = 1'b0; in_msg = 4'hA; out0_rdy = 1'b1;
    mid();
    chk("one_in_rdy", {7'd0, in_rdy}, 8'd1);
    chk("one_no_bypass", {7'd0, out0_val}, 8'd0);
    cyc();
    in_val = 1'b0;
    mid();
    chk("one_out0_val", {7'd0, out0_val}, 8'd1);
    chk("one_out0_msg", {4'd0, out0_msg}, 8'h0A);
    chk("one_out1_val", {7'd0, out1_val}, 8'd0);
    cyc();
    mid();
    chk("one_out0_idle", {7'd0, out0_val}, 8'd0);
`ifdef STREAM_DEMUX2_4B_COUNT_EN
    chk("one_out0_count", out0_count, 8'd1);
`endif

    // Fill out1 with its sink stalled
    cyc();
    in_val = 1'b1; in_sel = 1'b1; in_msg = 4'h3;
    mid();
    chk("fill_rdy_3", {7'd0, in_rdy}, 8'd1);
    cyc();
    in_msg = 4'h5;
    mid();
    chk("fill_rdy_5", {7'd0, in_rdy}, 8'd1);
    chk("fill_head_3", {4'd0, out1_msg}, 8'h03);
    cyc();
    in_msg = 4'h7;
    mid();
    chk("fill_full", {7'd0, in_rdy}, 8'd0);

    // Isolation: out0 still accepts while out1 is full
    cyc();
    in_sel = 1'b0; in_msg = 4'hC;
    mid();
    chk("iso_in_rdy", {7'd0, in_rdy}, 8'd1);
    cyc();
    in_sel = 1'b1; in_msg = 4'h7;
    mid();
    chk("iso_out0_val", {7'd0, out0_val}, 8'd1);
    chk("iso_out0_msg", {4'd0, out0_msg}, 8'h0C);
    chk("iso_out1_msg", {4'd0, out1_msg}, 8'h03);
    chk("iso_out1_full", {7'd0, in_rdy}, 8'd0);

    // Release out1: 3, 5, then the held 7
    cyc();
    out1_rdy = 1'b1;
    mid();
    chk("drain_full_deq_rdy", {7'd0, in_rdy}, 8'd0);
    chk("drain_msg_3", {4'd0, out1_msg}, 8'h03);
    cyc();
    mid();
    chk("drain_rdy_back", {7'd0, in_rdy}, 8'd1);
    chk("drain_msg_5", {4'd0, out1_msg}, 8'h05);
    cyc();
    in_val = 1'b0;
    mid();
    chk("drain_msg_7", {4'd0, out1_msg}, 8'h07);
    cyc();
    mid();
    chk("drain_empty", {7'd0, out1_val}, 8'd0);

    // out0 full with a concurrent dequeue refuses the enqueue
    cyc();
    out0_rdy = 1'b0; in_val = 1'b1; in_sel = 1'b0; in_msg = 4'h1;
    cyc();
    in_msg = 4'h2;
    cyc();
    in_msg = 4'h9; out0_rdy = 1'b1;
    mid();
    chk("fullcd_in_rdy", {7'd0, in_rdy}, 8'd0);
    chk("fullcd_head", {4'd0, out0_msg}, 8'h01);
    cyc();
    in_val = 1'b0; out0_rdy = 1'b0;
    mid();
    chk("fullcd_next", {4'd0, out0_msg}, 8'h02);
    chk("fullcd_rdy", {7'd0, in_rdy}, 8'd1);

    // Reset with both queues full
    cyc();
    in_val = 1'b1; in_sel = 1'b0; in_msg = 4'h4;
    cyc();
    in_sel = 1'b1; in_msg = 4'h6; out1_rdy = 1'b0;
    cyc();
    in_msg = 4'h8;
    cyc();
    in_val = 1'b0;
    mid();
    chk("rst_pre_out0_val", {7'd0, out0_val}, 8'd1);
    chk("rst_pre_out1_val", {7'd0, out1_val}, 8'd1);
    chk("rst_pre_in_rdy", {7'd0, in_rdy}, 8'd0);
    cyc();
    reset = 1'b1;
    mid();
    chk("rst_out0_val", {7'd0, out0_val}, 8'd0);
    chk("rst_out1_val", {7'd0, out1_val}, 8'd0);
    chk("rst_in_rdy", {7'd0, in_rdy}, 8'd0);
    cyc();
    reset = 1'b0; out0_rdy = 1'b1; out1_rdy = 1'b1;
    mid();
    chk("rst_after_in_rdy", {7'd0, in_rdy}, 8'd1);
    chk("rst_after_out0_val", {7'd0, out0_val}, 8'd0);
    chk("rst_after_out1_val", {7'd0, out1_val}, 8'd0);
    repeat (3) cyc();

    // 256 back-to-back messages to out1; in_rdy stays high throughout
    in_val = 1'b1; in_sel = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_msg = 4'($urandom_range(0, 15));
      cyc();
    end
    in_val = 1'b0;
    cyc();
    mid();
    chk("stream_out1_idle", {7'd0, out1_val}, 8'd0);
`ifdef STREAM_DEMUX2_4B_COUNT_EN
    chk("wrap_out1_count", out1_count, 8'd0);
    chk("wrap_out0_count", out0_count, 8'd0);
`endif

    // Random traffic, checked every cycle by the scoreboard
    for (int i = 0; i < 400; i++) begin
      cyc();
      in_val   = 1'($urandom_range(0, 1));
      in_sel   = 1'($urandom_range(0, 1));
      in_msg   = 4'($urandom_range(0, 15));
      out0_rdy = ($urandom_range(0, 3) != 0);
      out1_rdy = ($urandom_range(0, 2) == 0);
    end
    cyc();
    in_val = 1'b0; out0_rdy = 1'b1; out1_rdy = 1'b1;
    repeat (4) cyc();
    mid();
    chk("final_q0_empty", 8'(exp0_q.size()), 8'd0);
    chk("final_q1_empty", 8'(exp1_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
